// File: rtl/drawing_phase_sequencer_if.sv
// Control inputs and decoded strobe outputs of the drawing phase sequencer.
// The sequencer is the slave; the pixel timing logic and the datapath are on the master side.
interface drawing_phase_sequencer_if #(
    parameter int LAYERS = 1,
    parameter int PHASES = 4
);
    localparam int PW = ($clog2(PHASES) < 1) ? 1 : $clog2(PHASES);

    logic              enable;
    logic              sync;
    logic              one_shot;
    logic              start;
    logic [LAYERS-1:0] refresh_data_out;
    logic              refresh_vga_out;
    logic [PW-1:0]     phase;
    logic              busy;
    logic              cycle_done;

    modport master (
        output enable, sync, one_shot, start,
        input  refresh_data_out, refresh_vga_out, phase, busy, cycle_done
    );

    modport slave (
        input  enable, sync, one_shot, start,
        output refresh_data_out, refresh_vga_out, phase, busy, cycle_done
    );
endinterface

// File: rtl/drawing_phase_sequencer.sv
// Per-pixel phase sequencer: layer fetch strobes, then the VGA colour load, then settle phases.
// Moore outputs, one clock from sync/start to phase 0; enable=0 stalls and holds the current phase.
module drawing_phase_sequencer #(
    parameter int LAYERS      = 1,
    parameter int DATA_PHASES = 2,
    parameter int PHASES      = 4
) (
    input logic                     clk,
    input logic                     reset,
    drawing_phase_sequencer_if.slave bus
);
    localparam int PW = ($clog2(PHASES) < 1) ? 1 : $clog2(PHASES);
    localparam logic [PW-1:0] LAST_PH = PW'(PHASES - 1);
    localparam logic [PW-1:0] VGA_PH  = PW'(LAYERS * DATA_PHASES);

    if ((LAYERS < 1) || (LAYERS > 4)) begin : g_bad_layers
        $error("drawing_phase_sequencer: LAYERS must be in 1..4");
    end
    if ((DATA_PHASES < 1) || (DATA_PHASES > 4)) begin : g_bad_data_phases
        $error("drawing_phase_sequencer: DATA_PHASES must be in 1..4");
    end
    if ((PHASES < LAYERS * DATA_PHASES + 1) || (PHASES > 16)) begin : g_bad_phases
        $error("drawing_phase_sequencer: PHASES must be in LAYERS*DATA_PHASES+1..16");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PW-1:0]     r_ph;
    logic [PW-1:0]     w_ph_nxt;
    logic              w_run;
    logic              w_last;
    logic [LAYERS-1:0] w_data;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_ph    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ph    <= w_ph_nxt;
        end
    end

    assign w_last = (r_ph == LAST_PH);

    // sync outranks every state rule, including a stall with enable still low
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph;
        if (bus.sync) begin
            w_state_nxt = S_RUN;
            w_ph_nxt    = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_ph_nxt = '0;
                    if (!bus.one_shot || bus.start) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!bus.enable) begin
                        w_state_nxt = S_STALL;
                    end else if (w_last) begin
                        w_ph_nxt = '0;
                        if (bus.one_shot) begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_ph_nxt = r_ph + PW'(1);
                    end
                end
                S_STALL: begin
                    if (bus.enable) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_ph_nxt    = '0;
                end
            endcase
        end
    end

    assign w_run = (r_state == S_RUN);

    // Layer k owns the phase window [k*DATA_PHASES, (k+1)*DATA_PHASES)
    for (genvar k = 0; k < LAYERS; k++) begin : g_layer
        localparam logic [PW-1:0] LO = PW'(k * DATA_PHASES);
        localparam logic [PW-1:0] HI = PW'((k + 1) * DATA_PHASES);
        if (k == 0) begin : g_first
            assign w_data[k] = w_run && (r_ph < HI);
        end else begin : g_rest
            assign w_data[k] = w_run && (r_ph >= LO) && (r_ph < HI);
        end
    end

    assign bus.refresh_data_out = w_data;
    assign bus.refresh_vga_out  = w_run && (r_ph == VGA_PH);
    assign bus.cycle_done       = w_run && w_last;
    assign bus.busy             = (r_state != S_IDLE);
    assign bus.phase            = (r_state == S_IDLE) ? '0 : r_ph;
endmodule
